mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width and width of the HI and LO registers.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, N bits: rs operand (multiplicand or dividend).
REQ-007 SHALL have port b, input, N bits: rt operand (multiplier or divisor).
REQ-008 SHALL have port flush, input, 1 bit: synchronous abort of the operation in flight.
REQ-009 SHALL have port hi, output, N bits: HI register (product high word or remainder).
REQ-010 SHALL have port lo, output, N bits: LO register (product low word or quotient).
REQ-011 SHALL have port busy, output, 1 bit: high in the MUL, DIV and FIX states.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse, high in the DONE state.
REQ-013 SHALL have port stall, output, 1 bit: combinational; equals busy OR (state==IDLE AND start); freezes the CPU PC and register-file writes.
REQ-014 SHALL have port dbz, output, 1 bit: sticky divide-by-zero flag; cleared by the next accepted start.

Function
REQ-015 SHALL implement the FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-016 SHALL, in IDLE with start=1, latch a, b and op, and go to MUL for op[1]=0 or to DIV for op[1]=1, with count=0.
REQ-017 SHALL, in MUL, perform one shift-add step per cycle on operand magnitudes for 32 cycles (count 0..31), then go to FIX.
REQ-018 SHALL, in DIV, perform one restoring-division step per cycle on magnitudes for 32 cycles, then go to FIX.
REQ-019 SHALL, in FIX, apply sign correction for signed ops: for MULT, negate the 64-bit product when the operand signs differ; for DIV, negate the quotient when the signs differ and give the remainder the dividend's sign (truncating division). Then go to DONE.
REQ-020 SHALL, in DONE, have hi and lo already holding the new result (registered on the FIX->DONE edge), assert done, and return to IDLE on the next cycle.
REQ-021 SHALL have a latency of 34 cycles from the start edge to the edge on which done is first high, for all nonzero-divisor operations.
REQ-022 SHALL, for DIV or DIVU with b==0, go from IDLE to DONE directly, with hi=a, lo=all-ones and dbz=1 (latency 1 cycle).
REQ-023 SHALL, for DIV of -2^(N-1) by -1, produce lo=0x80000000 and hi=0 with no flag.
REQ-024 SHALL ignore start while busy or in DONE; no queuing.
REQ-025 SHALL, on flush=1 in any state, return to IDLE on the next edge, leave hi/lo/dbz unchanged and suppress done; flush dominates start in the same cycle.
REQ-026 SHALL use an internal 6-bit-or-wider count and a 2N-bit working register; no arithmetic result wider than 2N bits.

Reset
REQ-027 SHALL, while reset_n=0, immediately force state=IDLE, hi=0, lo=0, dbz=0, busy=0, done=0 and count=0, including mid-operation.
REQ-028 SHALL give the first usable start edge as the first rising clk after reset_n deasserts.

Structure
REQ-029 SHALL place the op encoding enum, the FSM state enum and the constant N=32 in shared package mdu_pkg.
REQ-030 SHALL use no sub-module; the FSM and the iterative datapath are one module, with an optional magnitude/negate function in mdu_pkg.

Verification
REQ-031 SHALL verify reset: reset_n low -> hi=0, lo=0, busy=0, done=0, stall=0, dbz=0.
REQ-032 SHALL verify MULT: a=0xFFFFFFFD, b=7 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL verify division: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-034 SHALL verify divide-by-zero: DIVU a=0x1234, b=0 -> done 1 cycle after start, hi=0x1234, lo=0xFFFFFFFF, dbz=1; the next start clears dbz.
REQ-035 SHALL verify start while busy and flush: start held high during MUL -> exactly one done; flush at cycle 10 of DIV -> IDLE, no done, hi/lo unchanged.
REQ-036 SHALL verify reset mid-operation: reset_n low at cycle 20 of MULT -> immediate IDLE, hi=lo=0; a fresh MULTU 3x5 afterward -> lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_N = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: shift-add and restoring division
// on magnitudes, followed by one sign-fixup cycle.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         stall,
    output logic         dbz
);

    localparam int CW = ($clog2(N) + 1 > 6) ? $clog2(N) + 1 : 6;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e state, state_nx;

    logic [CW-1:0]  count;
    logic [2*N-1:0] work;
    logic [N-1:0]   dvs;
    logic           neg_q;
    logic           neg_r;
    logic           div_l;

    op_e          opc;
    logic         is_div;
    logic         sgn;
    logic         a_neg;
    logic         b_neg;
    logic         b_zero;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;

    assign opc    = op_e'(op);
    assign is_div = (opc == OP_DIV) || (opc == OP_DIVU);
    assign sgn    = (opc == OP_MULT) || (opc == OP_DIV);
    assign a_neg  = sgn & a[N-1];
    assign b_neg  = sgn & b[N-1];
    assign b_zero = (b == '0);
    assign a_mag  = a_neg ? (~a + 1'b1) : a;
    assign b_mag  = b_neg ? (~b + 1'b1) : b;

    // Shift-add step: low half holds the remaining multiplier bits
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_nx;

    // Restoring step: upper half is the partial remainder
    logic [N:0]     div_top;
    logic [N:0]     div_diff;
    logic           div_ge;
    logic [2*N-1:0] div_nx;

    logic [2*N-1:0] prod_neg;
    logic [N-1:0]   res_hi;
    logic [N-1:0]   res_lo;

    always_comb begin
        mul_sum  = {1'b0, work[2*N-1:N]} + {1'b0, dvs};
        mul_nx   = work[0] ? {mul_sum, work[N-1:1]}
                           : {1'b0, work[2*N-1:1]};
        div_top  = work[2*N-1:N-1];
        div_diff = div_top - {1'b0, dvs};
        div_ge   = (div_top >= {1'b0, dvs});
        div_nx   = {div_ge ? div_diff[N-1:0] : div_top[N-1:0],
                    work[N-2:0], div_ge};
        prod_neg = ~work + 1'b1;
        res_hi   = work[2*N-1:N];
        res_lo   = work[N-1:0];
        if (div_l) begin
            if (neg_q) res_lo = ~work[N-1:0] + 1'b1;
            if (neg_r) res_hi = ~work[2*N-1:N] + 1'b1;
        end else if (neg_q) begin
            res_hi = prod_neg[2*N-1:N];
            res_lo = prod_neg[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (!is_div)     state_nx = S_MUL;
                    else if (b_zero) state_nx = S_DONE;
                    else             state_nx = S_DIV;
                end
            end
            S_MUL:  if (count == LAST) state_nx = S_FIX;
            S_DIV:  if (count == LAST) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            work  <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div_l <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            dbz   <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= '0;
                        div_l <= is_div;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dbz   <= is_div & b_zero;
                        if (is_div) begin
                            work <= {{N{1'b0}}, a_mag};
                            dvs  <= b_mag;
                        end else begin
                            work <= {{N{1'b0}}, b_mag};
                            dvs  <= a_mag;
                        end
                        if (is_div && b_zero) begin
                            hi <= a;
                            lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    work  <= mul_nx;
                    count <= count + 1'b1;
                end
                S_DIV: begin
                    work  <= div_nx;
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == S_MUL) || (state == S_DIV) ||
                   (state == S_FIX);
    assign done  = (state == S_DONE);
    assign stall = busy || ((state == S_IDLE) && start);

endmodule
